// File: rtl/carry_skip_adder_pipe.sv
// rtl/carry_skip_adder_pipe.sv - pipelined carry-skip adder, one skip block per stage
// Stage k registers the result of block k; the last stage register drives the outputs.
module carry_skip_adder_pipe #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4,
    localparam int NBLK = WIDTH / BLOCK,
    localparam int SW = $clog2(NBLK + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [SW-1:0]    skip_cnt
);

    logic adv;

    // Whole pipe advances together; a blocked output freezes every stage.
    assign in_ready = !out_valid || out_ready;
    assign adv      = in_ready;

    for (genvar k = 0; k < NBLK; k++) begin : g_stg
        logic [BLOCK-1:0]         ba, bb, p, g, bs;
        logic [BLOCK:0]           cc;
        logic                     ci, co, skip, vi;
        logic [SW-1:0]            ki;
        logic [(k+1)*BLOCK-1:0]   s_d, s_q;
        logic                     vld_q, c_q;
        logic [SW-1:0]            k_q;

        if (k == 0) begin : g_src
            assign ba  = a[BLOCK-1:0];
            assign bb  = b[BLOCK-1:0];
            assign ci  = cin;
            assign ki  = '0;
            assign vi  = in_valid && in_ready;
            assign s_d = bs;
        end else begin : g_src
            assign ba  = g_stg[k-1].g_ops.qa[BLOCK-1:0];
            assign bb  = g_stg[k-1].g_ops.qb[BLOCK-1:0];
            assign ci  = g_stg[k-1].c_q;
            assign ki  = g_stg[k-1].k_q;
            assign vi  = g_stg[k-1].vld_q;
            assign s_d = {bs, g_stg[k-1].s_q};
        end

        always_comb begin
            p     = ba ^ bb;
            g     = ba & bb;
            cc    = '0;
            cc[0] = ci;
            for (int i = 0; i < BLOCK; i++) begin
                cc[i+1] = g[i] | (p[i] & cc[i]);
            end
            bs   = p ^ cc[BLOCK-1:0];
            skip = &p;
            co   = skip ? ci : cc[BLOCK];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= 1'b0;
                s_q   <= '0;
                c_q   <= 1'b0;
                k_q   <= '0;
            end else if (adv) begin
                vld_q <= vi;
                s_q   <= s_d;
                c_q   <= co;
                k_q   <= ki + SW'(skip);
            end
        end

        // Only the operand bits of blocks not yet summed travel down the pipe.
        if (k < NBLK - 1) begin : g_ops
            localparam int RW = WIDTH - (k + 1) * BLOCK;
            logic [RW-1:0] qa, qb, na, nb;

            if (k == 0) begin : g_nx
                assign na = a[WIDTH-1:BLOCK];
                assign nb = b[WIDTH-1:BLOCK];
            end else begin : g_nx
                assign na = g_stg[k-1].g_ops.qa[RW+BLOCK-1:BLOCK];
                assign nb = g_stg[k-1].g_ops.qb[RW+BLOCK-1:BLOCK];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    qa <= '0;
                    qb <= '0;
                end else if (adv) begin
                    qa <= na;
                    qb <= nb;
                end
            end
        end

        if (k == NBLK - 1) begin : g_last
            logic ovf_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= co ^ cc[BLOCK-1];
                end
            end
        end
    end

    assign out_valid = g_stg[NBLK-1].vld_q;
    assign sum       = g_stg[NBLK-1].s_q;
    assign cout      = g_stg[NBLK-1].c_q;
    assign ovf       = g_stg[NBLK-1].g_last.ovf_q;
    assign skip_cnt  = g_stg[NBLK-1].k_q;

endmodule

// File: tb/tb_carry_skip_adder_pipe.sv
// tb/tb_carry_skip_adder_pipe.sv - scoreboard bench for carry_skip_adder_pipe
module tb_carry_skip_adder_pipe;

    typedef struct packed {
        logic [31:0] s;
        logic        co;
        logic        ov;
        logic [2:0]  sk;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        iv16 = 1'b0, ir16, ov16, or16 = 1'b1, ci16 = 1'b0, co16, of16;
    logic [15:0] a16 = '0, b16 = '0, s16;
    logic [2:0]  sk16;

    logic        iv32 = 1'b0, ir32, ov32, or32 = 1'b1, ci32 = 1'b0, co32, of32;
    logic [31:0] a32 = '0, b32 = '0, s32;
    logic [2:0]  sk32;

    exp_t q16[$];
    exp_t q32[$];
    int   errors = 0;
    int   checks = 0;
    int   n_acc32 = 0;
    int   n_out32 = 0;

    always #5 clk = ~clk;

    carry_skip_adder_pipe #(.WIDTH(16), .BLOCK(4)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .cin(ci16), .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16),
        .ovf(of16), .skip_cnt(sk16)
    );

    carry_skip_adder_pipe #(.WIDTH(32), .BLOCK(8)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
        .cin(ci32), .out_valid(ov32), .out_ready(or32), .sum(s32), .cout(co32),
        .ovf(of32), .skip_cnt(sk32)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] s, input logic co, input logic ov,
                                input logic [2:0] sk);
        exp_t e;
        e.s  = s;
        e.co = co;
        e.ov = ov;
        e.sk = sk;
        return e;
    endfunction

    function automatic exp_t model32(input logic [31:0] x, input logic [31:0] y, input logic c);
        logic [32:0] t;
        exp_t e;
        t    = {1'b0, x} + {1'b0, y} + {32'b0, c};
        e.s  = t[31:0];
        e.co = t[32];
        e.ov = (x[31] == y[31]) && (t[31] != x[31]);
        e.sk = '0;
        for (int j = 0; j < 4; j++) begin
            if ((((x ^ y) >> (8 * j)) & 32'hFF) == 32'hFF) e.sk = e.sk + 3'd1;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst && ov16 && or16) begin
            if (q16.size() == 0) begin
                check("spurious16", ov16, 0);
            end else begin
                e = q16.pop_front();
                check("sum16", s16, e.s[15:0]);
                check("cout16", co16, e.co);
                check("ovf16", of16, e.ov);
                check("skip16", sk16, e.sk);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (ov32 && or32) begin
                n_out32++;
                if (q32.size() == 0) begin
                    check("spurious32", ov32, 0);
                end else begin
                    e = q32.pop_front();
                    check("sum32", s32, e.s);
                    check("cout32", co32, e.co);
                    check("ovf32", of32, e.ov);
                    check("skip32", sk32, e.sk);
                end
            end
            if (iv32 && ir32) begin
                q32.push_back(model32(a32, b32, ci32));
                n_acc32++;
            end
        end
    end

    // Leaves in_valid asserted so calls can stream back to back.
    task automatic send16(input logic [15:0] x, input logic [15:0] y, input logic c,
                          input logic push, input exp_t e);
        logic acc;
        acc  = 1'b0;
        iv16 = 1'b1;
        a16  = x;
        b16  = y;
        ci16 = c;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = iv16 && ir16 && !rst;
            if (acc && push) q16.push_back(e);
            @(posedge clk);
            #1;
        end
        check("accept16", acc, 1);
    endtask

    task automatic drain16();
        for (int n = 0; n < 100 && q16.size() != 0; n++) begin
            @(posedge clk);
        end
        #1;
        check("drain16", q16.size(), 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ovalid", ov16, 0);
        check("rst_sum", s16, 0);
        check("rst_cout", co16, 0);
        check("rst_ovf", of16, 0);
        check("rst_skip", sk16, 0);
        check("rst_iready", ir16, 1);
        @(posedge clk);
        #1;

        send16(16'hFFFF, 16'h0001, 1'b0, 1'b1, mk(32'h0000, 1'b1, 1'b0, 3'd3));
        iv16 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("latency16", ov16, i == 3);
            if (i < 3) @(posedge clk);
        end
        @(posedge clk);
        #1;

        send16(16'h7FFF, 16'h0001, 1'b0, 1'b1, mk(32'h8000, 1'b0, 1'b1, 3'd2));
        send16(16'h0000, 16'hFFFF, 1'b1, 1'b1, mk(32'h0000, 1'b1, 1'b0, 3'd4));
        iv16 = 1'b0;
        drain16();

        fork
            begin
                send16(16'h0001, 16'h0001, 1'b0, 1'b1, mk(32'h0002, 1'b0, 1'b0, 3'd0));
                send16(16'h00FF, 16'h0001, 1'b0, 1'b1, mk(32'h0100, 1'b0, 1'b0, 3'd1));
                send16(16'h0F0F, 16'hF0F0, 1'b0, 1'b1, mk(32'hFFFF, 1'b0, 1'b0, 3'd4));
                send16(16'h8000, 16'h8000, 1'b0, 1'b1, mk(32'h0000, 1'b1, 1'b1, 3'd0));
                send16(16'h1234, 16'h4321, 1'b0, 1'b1, mk(32'h5555, 1'b0, 1'b0, 3'd0));
                send16(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, mk(32'hFFFE, 1'b1, 1'b0, 3'd0));
                iv16 = 1'b0;
            end
            begin
                logic [15:0] s0;
                logic [2:0]  k0;
                logic        c0;
                repeat (5) @(posedge clk);
                #1 or16 = 1'b0;
                @(negedge clk);
                s0 = s16;
                k0 = sk16;
                c0 = co16;
                check("stall_ovalid", ov16, 1);
                check("stall_iready", ir16, 0);
                @(posedge clk);
                @(negedge clk);
                check("stall_sum", s16, s0);
                check("stall_skip", sk16, k0);
                check("stall_cout", co16, c0);
                check("stall_ovalid2", ov16, 1);
                check("stall_iready2", ir16, 0);
                @(posedge clk);
                #1 or16 = 1'b1;
            end
        join
        drain16();

        send16(16'h1111, 16'h2222, 1'b0, 1'b0, mk(32'h0, 1'b0, 1'b0, 3'd0));
        send16(16'h3333, 16'h4444, 1'b1, 1'b0, mk(32'h0, 1'b0, 1'b0, 3'd0));
        iv16 = 1'b0;
        rst  = 1'b1;
        or16 = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst2_ovalid", ov16, 0);
        check("rst2_sum", s16, 0);
        check("rst2_cout", co16, 0);
        check("rst2_ovf", of16, 0);
        check("rst2_skip", sk16, 0);
        check("rst2_iready", ir16, 1);
        or16 = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("rst2_flushed", q16.size(), 0);

        for (int cyc = 0; cyc < 20000 && n_acc32 < 1000; cyc++) begin
            iv32 = ($urandom_range(0, 7) != 0);
            a32  = $urandom;
            case ($urandom_range(0, 3))
                0:       b32 = ~a32;
                1:       b32 = ~a32 ^ (32'h1 << $urandom_range(0, 31));
                default: b32 = $urandom;
            endcase
            ci32 = 1'($urandom_range(0, 1));
            or32 = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        iv32 = 1'b0;
        or32 = 1'b1;
        check("acc32", n_acc32, 1000);
        for (int n = 0; n < 100 && q32.size() != 0; n++) begin
            @(posedge clk);
        end
        #1;
        check("out32", n_out32, 1000);
        check("drain32", q32.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
